message_sequencer: RTL

//  Sequences the 14-char message ROM (index mess, addr 0..13, registered 1-cycle read) onto the serial transmitter.

---
 rtl/message_sequencer_pkg.sv | 16 +
 rtl/message_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/message_sequencer_pkg.sv
// Shared encodings and sizing for the message ROM sequencer.
package message_sequencer_pkg;

  localparam int MSG_LEN_DEF  = 14;
  localparam int MIN_MESS_DEF = 1;
  localparam int MAX_MESS_DEF = 17;
  localparam int ADDR_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/message_sequencer.sv
// Walks one message of the character ROM onto the serial transmitter, one byte per
// new_tx_data strobe, with a single-entry pending slot for requests that arrive mid-message.
module message_sequencer
  import message_sequencer_pkg::*;
#(
  parameter int MSG_LEN  = MSG_LEN_DEF,
  parameter int MIN_MESS = MIN_MESS_DEF,
  parameter int MAX_MESS = MAX_MESS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [7:0]        req_mess,
  output logic [7:0]        rom_mess,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              req_err,
  output logic              done
);

  state_e            state_q, state_d;
  logic [7:0]        rom_mess_q, rom_mess_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_data_q, new_tx_data_d;
  logic              req_err_q, req_err_d;
  logic              done_q, done_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        pend_mess_q, pend_mess_d;
  logic              req_ok;
  logic              last_addr;

  function automatic logic mess_valid(input logic [7:0] m);
    return (m >= 8'(MIN_MESS)) && (m <= 8'(MAX_MESS));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rom_mess_q    <= '0;
      rom_addr_q    <= '0;
      tx_data_q     <= '0;
      new_tx_data_q <= 1'b0;
      req_err_q     <= 1'b0;
      done_q        <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_mess_q   <= '0;
    end else begin
      state_q       <= state_d;
      rom_mess_q    <= rom_mess_d;
      rom_addr_q    <= rom_addr_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      req_err_q     <= req_err_d;
      done_q        <= done_d;
      pend_vld_q    <= pend_vld_d;
      pend_mess_q   <= pend_mess_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_mess_d    = rom_mess_q;
    rom_addr_d    = rom_addr_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    done_d        = 1'b0;
    pend_vld_d    = pend_vld_q;
    pend_mess_d   = pend_mess_q;
    req_ok        = req && mess_valid(req_mess);
    last_addr     = (rom_addr_q == ADDR_W'(MSG_LEN - 1));
    // In IDLE the pending slot empties as it launches, so a new valid request can refill it.
    req_err_d     = req && (!mess_valid(req_mess) || (state_q != ST_IDLE && pend_vld_q));

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          rom_mess_d = pend_mess_q;
          rom_addr_d = '0;
          state_d    = ST_ADDR;
          pend_vld_d = req_ok;
          if (req_ok) pend_mess_d = req_mess;
        end else if (req_ok) begin
          rom_mess_d = req_mess;
          rom_addr_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (!tx_busy) begin
          tx_data_d     = rom_data;
          new_tx_data_d = 1'b1;
          done_d        = last_addr;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        // tx_busy only rises a cycle after the strobe, so it is not looked at here.
        if (last_addr) begin
          state_d = ST_IDLE;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && req_ok && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_mess_d = req_mess;
    end
  end

  assign rom_mess    = rom_mess_q;
  assign rom_addr    = rom_addr_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign req_err     = req_err_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE) || pend_vld_q;

endmodule
